// File: rtl/lsu_issue_queue_if.sv
// Dispatch-side and issue-side signals of the LSU issue queue, bundled so the
// queue and its driver share one port definition.
interface lsu_issue_queue_if #(
    parameter int PAYLOAD_W = 64,
    parameter int TAG_W     = 6,
    parameter int CNT_W     = 4
);
    logic                 flush;
    logic                 wen_0;
    logic                 wen_1;
    logic [PAYLOAD_W-1:0] payload_0;
    logic [PAYLOAD_W-1:0] payload_1;
    logic [TAG_W-1:0]     src0_tag_0;
    logic [TAG_W-1:0]     src1_tag_0;
    logic [TAG_W-1:0]     src0_tag_1;
    logic [TAG_W-1:0]     src1_tag_1;
    logic                 src0_rdy_0;
    logic                 src1_rdy_0;
    logic                 src0_rdy_1;
    logic                 src1_rdy_1;
    logic                 wk_valid_0;
    logic                 wk_valid_1;
    logic [TAG_W-1:0]     wk_tag_0;
    logic [TAG_W-1:0]     wk_tag_1;
    logic                 issue_stall;
    logic                 issue_valid;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic                 full;
    logic [CNT_W-1:0]     count;

    modport master (
        output flush, wen_0, wen_1, payload_0, payload_1,
               src0_tag_0, src1_tag_0, src0_tag_1, src1_tag_1,
               src0_rdy_0, src1_rdy_0, src0_rdy_1, src1_rdy_1,
               wk_valid_0, wk_valid_1, wk_tag_0, wk_tag_1, issue_stall,
        input  issue_valid, issue_payload, full, count
    );

    modport slave (
        input  flush, wen_0, wen_1, payload_0, payload_1,
               src0_tag_0, src1_tag_0, src0_tag_1, src1_tag_1,
               src0_rdy_0, src1_rdy_0, src0_rdy_1, src1_rdy_1,
               wk_valid_0, wk_valid_1, wk_tag_0, wk_tag_1, issue_stall,
        output issue_valid, issue_payload, full, count
    );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order LSU issue queue: two writes per cycle, operand wakeup with
// write-time bypass, single in-order issue from the head entry.
module lsu_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 64,
    parameter int TAG_W     = 6
) (
    input  logic            clk,
    input  logic            rst,
    lsu_issue_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [TAG_W-1:0]     r_tag0    [DEPTH];
    logic [TAG_W-1:0]     r_tag1    [DEPTH];
    logic [DEPTH-1:0]     r_rdy0;
    logic [DEPTH-1:0]     r_rdy1;
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;

    logic [1:0]    w_nwr;
    logic [1:0]    w_nwr_acc;
    logic [CW:0]   w_sum;
    logic          w_fits;
    logic          w_drop;
    logic          w_issue;
    logic          w_we0;
    logic          w_we1;
    logic [PW-1:0] w_idx1;
    logic          w_rdy00, w_rdy10, w_rdy01, w_rdy11;

    function automatic logic f_hit(input logic [TAG_W-1:0] tag,
                                   input logic v0, input logic [TAG_W-1:0] t0,
                                   input logic v1, input logic [TAG_W-1:0] t1);
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    assign w_issue = (r_count != '0) && r_rdy0[r_head] && r_rdy1[r_head] && !bus.issue_stall;
    assign w_nwr   = {1'b0, bus.wen_0} + {1'b0, bus.wen_1};

    // A write group is taken whole or not at all, accounting for a same-cycle issue.
    assign w_sum     = {1'b0, r_count} + (CW+1)'(w_nwr) - (CW+1)'(w_issue);
    assign w_fits    = (w_sum <= (CW+1)'(DEPTH));
    assign w_drop    = (w_nwr != 2'd0) && !w_fits && !bus.flush;
    assign w_nwr_acc = (w_fits && !bus.flush) ? w_nwr : 2'd0;
    assign w_we0     = bus.wen_0 && w_fits && !bus.flush;
    assign w_we1     = bus.wen_1 && w_fits && !bus.flush;
    assign w_idx1    = bus.wen_0 ? r_tail + PW'(1) : r_tail;

    assign w_rdy00 = bus.src0_rdy_0 | f_hit(bus.src0_tag_0, bus.wk_valid_0, bus.wk_tag_0, bus.wk_valid_1, bus.wk_tag_1);
    assign w_rdy10 = bus.src1_rdy_0 | f_hit(bus.src1_tag_0, bus.wk_valid_0, bus.wk_tag_0, bus.wk_valid_1, bus.wk_tag_1);
    assign w_rdy01 = bus.src0_rdy_1 | f_hit(bus.src0_tag_1, bus.wk_valid_0, bus.wk_tag_0, bus.wk_valid_1, bus.wk_tag_1);
    assign w_rdy11 = bus.src1_rdy_1 | f_hit(bus.src1_tag_1, bus.wk_valid_0, bus.wk_tag_0, bus.wk_valid_1, bus.wk_tag_1);

    assign bus.issue_valid   = w_issue;
    assign bus.issue_payload = r_payload[r_head];
    assign bus.count         = r_count;
    assign bus.full          = (CW'(DEPTH) - r_count) < CW'(2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (bus.flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + PW'(w_issue);
                r_tail  <= r_tail + PW'(w_nwr_acc);
                r_count <= r_count + CW'(w_nwr_acc) - CW'(w_issue);
            end
        end
    end

    // Wakeup marks any matching entry; a same-edge write to that slot overrides it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy0 <= '0;
            r_rdy1 <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (f_hit(r_tag0[i], bus.wk_valid_0, bus.wk_tag_0, bus.wk_valid_1, bus.wk_tag_1))
                    r_rdy0[i] <= 1'b1;
                if (f_hit(r_tag1[i], bus.wk_valid_0, bus.wk_tag_0, bus.wk_valid_1, bus.wk_tag_1))
                    r_rdy1[i] <= 1'b1;
            end
            if (w_we0) begin
                r_rdy0[r_tail] <= w_rdy00;
                r_rdy1[r_tail] <= w_rdy10;
            end
            if (w_we1) begin
                r_rdy0[w_idx1] <= w_rdy01;
                r_rdy1[w_idx1] <= w_rdy11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we0) begin
            r_payload[r_tail] <= bus.payload_0;
            r_tag0[r_tail]    <= bus.src0_tag_0;
            r_tag1[r_tail]    <= bus.src1_tag_0;
        end
        if (w_we1) begin
            r_payload[w_idx1] <= bus.payload_1;
            r_tag0[w_idx1]    <= bus.src0_tag_1;
            r_tag1[w_idx1]    <= bus.src1_tag_1;
        end
    end

    a_overflow_cause: assert property (@(posedge clk) disable iff (!rst)
        $rose(r_overflow) |-> $past(w_drop));
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed bench for lsu_issue_queue with a payload scoreboard and an
// independent issue monitor.
module tb_lsu_issue_queue;
    localparam int DEPTH = 8;
    localparam int PW    = 64;
    localparam int TW    = 6;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [PW-1:0] exp_q[$];

    lsu_issue_queue_if #(.PAYLOAD_W(PW), .TAG_W(TW), .CNT_W(CW)) u_if ();

    lsu_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .TAG_W(TW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic clear_in();
        u_if.wen_0 = 1'b0; u_if.wen_1 = 1'b0;
        u_if.wk_valid_0 = 1'b0; u_if.wk_valid_1 = 1'b0;
        u_if.wk_tag_0 = '0; u_if.wk_tag_1 = '0;
        u_if.flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic drive(input int slot, input logic [PW-1:0] pl,
                         input logic [TW-1:0] t0, input logic r0,
                         input logic [TW-1:0] t1, input logic r1);
        if (slot == 0) begin
            u_if.wen_0 = 1'b1; u_if.payload_0 = pl;
            u_if.src0_tag_0 = t0; u_if.src0_rdy_0 = r0;
            u_if.src1_tag_0 = t1; u_if.src1_rdy_0 = r1;
        end else begin
            u_if.wen_1 = 1'b1; u_if.payload_1 = pl;
            u_if.src0_tag_1 = t0; u_if.src0_rdy_1 = r0;
            u_if.src1_tag_1 = t1; u_if.src1_rdy_1 = r1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && u_if.count != '0; k++) step();
        chk("drain_count", 64'(u_if.count), 64'd0);
    endtask

    // Issue monitor: pops the expected payload whenever the queue issues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && u_if.issue_valid && !u_if.flush) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_issue: got %0h, expected no issue", u_if.issue_payload);
                end else begin
                    chk("issue_payload", u_if.issue_payload, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        u_if.issue_stall = 1'b0;
        u_if.payload_0 = '0; u_if.payload_1 = '0;
        u_if.src0_tag_0 = '0; u_if.src1_tag_0 = '0; u_if.src0_tag_1 = '0; u_if.src1_tag_1 = '0;
        u_if.src0_rdy_0 = 1'b0; u_if.src1_rdy_0 = 1'b0; u_if.src0_rdy_1 = 1'b0; u_if.src1_rdy_1 = 1'b0;
        clear_in();
        @(posedge clk);
        @(negedge clk);
        chk("reset_count", 64'(u_if.count), 64'd0);
        chk("reset_valid", 64'(u_if.issue_valid), 64'd0);
        chk("reset_full", 64'(u_if.full), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // dual write, both ready
        drive(0, 64'hA, 6'd1, 1'b1, 6'd2, 1'b1);
        drive(1, 64'hB, 6'd3, 1'b1, 6'd4, 1'b1);
        exp_q.push_back(64'hA); exp_q.push_back(64'hB);
        step();
        @(negedge clk);
        chk("dual_valid0", 64'(u_if.issue_valid), 64'd1);
        chk("dual_count0", 64'(u_if.count), 64'd2);
        step();
        @(negedge clk);
        chk("dual_valid1", 64'(u_if.issue_valid), 64'd1);
        chk("dual_count1", 64'(u_if.count), 64'd1);
        step();
        @(negedge clk);
        chk("dual_empty_count", 64'(u_if.count), 64'd0);
        chk("dual_empty_valid", 64'(u_if.issue_valid), 64'd0);

        // in-order block behind a head waiting on tag 5
        step();
        drive(0, 64'h21, 6'd3, 1'b1, 6'd5, 1'b0);
        drive(1, 64'h22, 6'd7, 1'b1, 6'd8, 1'b1);
        exp_q.push_back(64'h21); exp_q.push_back(64'h22);
        step();
        @(negedge clk);
        chk("block_valid", 64'(u_if.issue_valid), 64'd0);
        chk("block_count", 64'(u_if.count), 64'd2);
        step();
        u_if.wk_valid_0 = 1'b1; u_if.wk_tag_0 = 6'd5;
        @(negedge clk);
        chk("wake_same_cycle_valid", 64'(u_if.issue_valid), 64'd0);
        step();
        @(negedge clk);
        chk("wake_next_valid", 64'(u_if.issue_valid), 64'd1);
        step();
        @(negedge clk);
        chk("wake_second_valid", 64'(u_if.issue_valid), 64'd1);
        chk("wake_second_count", 64'(u_if.count), 64'd1);
        step();
        @(negedge clk);
        chk("wake_done_count", 64'(u_if.count), 64'd0);

        // write-time bypass from wakeup port 1
        step();
        drive(0, 64'h33, 6'd12, 1'b0, 6'd13, 1'b1);
        u_if.wk_valid_1 = 1'b1; u_if.wk_tag_1 = 6'd12;
        exp_q.push_back(64'h33);
        step();
        @(negedge clk);
        chk("bypass_valid", 64'(u_if.issue_valid), 64'd1);
        chk("bypass_count", 64'(u_if.count), 64'd1);
        step();
        @(negedge clk);
        chk("bypass_done_count", 64'(u_if.count), 64'd0);

        // fill to 7, issue with single write, dropped dual write
        step();
        u_if.issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 64'h40 + 64'(2*i), 6'd1, 1'b1, 6'd2, 1'b1);
            drive(1, 64'h41 + 64'(2*i), 6'd1, 1'b1, 6'd2, 1'b1);
            exp_q.push_back(64'h40 + 64'(2*i)); exp_q.push_back(64'h41 + 64'(2*i));
            step();
        end
        @(negedge clk);
        chk("fill6_count", 64'(u_if.count), 64'd6);
        chk("fill6_full", 64'(u_if.full), 64'd0);
        step();
        drive(0, 64'h46, 6'd1, 1'b1, 6'd2, 1'b1);
        exp_q.push_back(64'h46);
        step();
        @(negedge clk);
        chk("fill7_count", 64'(u_if.count), 64'd7);
        chk("fill7_full", 64'(u_if.full), 64'd1);
        step();
        u_if.issue_stall = 1'b0;
        drive(0, 64'h47, 6'd1, 1'b1, 6'd2, 1'b1);
        exp_q.push_back(64'h47);
        @(negedge clk);
        chk("full_issue_valid", 64'(u_if.issue_valid), 64'd1);
        step();
        u_if.issue_stall = 1'b1;
        drive(0, 64'h48, 6'd1, 1'b1, 6'd2, 1'b1);
        drive(1, 64'h49, 6'd1, 1'b1, 6'd2, 1'b1);
        @(negedge clk);
        chk("issue_write_count", 64'(u_if.count), 64'd7);
        chk("stalled_valid", 64'(u_if.issue_valid), 64'd0);
        step();
        @(negedge clk);
        chk("drop_count", 64'(u_if.count), 64'd7);
        chk("drop_full", 64'(u_if.full), 64'd1);
        step();
        u_if.issue_stall = 1'b0;
        drain();

        // streaming across pointer wrap, alternating write slots
        for (int i = 0; i < 20; i++) begin
            drive(i % 2, 64'h100 + 64'(i), 6'd9, 1'b1, 6'd10, 1'b1);
            exp_q.push_back(64'h100 + 64'(i));
            step();
        end
        drain();

        // flush with concurrent write
        u_if.issue_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(0, 64'h60 + 64'(2*i), 6'd1, 1'b1, 6'd2, 1'b1);
            drive(1, 64'h61 + 64'(2*i), 6'd1, 1'b1, 6'd2, 1'b1);
            step();
        end
        drive(0, 64'h64, 6'd1, 1'b1, 6'd2, 1'b1);
        step();
        @(negedge clk);
        chk("preflush_count", 64'(u_if.count), 64'd5);
        step();
        u_if.issue_stall = 1'b0;
        u_if.flush = 1'b1;
        drive(0, 64'h65, 6'd1, 1'b1, 6'd2, 1'b1);
        @(negedge clk);
        chk("flush_cycle_valid", 64'(u_if.issue_valid), 64'd1);
        step();
        @(negedge clk);
        chk("postflush_count", 64'(u_if.count), 64'd0);
        chk("postflush_valid", 64'(u_if.issue_valid), 64'd0);

        // asynchronous reset between edges
        step();
        u_if.issue_stall = 1'b1;
        drive(0, 64'h70, 6'd1, 1'b1, 6'd2, 1'b1);
        drive(1, 64'h71, 6'd1, 1'b1, 6'd2, 1'b1);
        step();
        @(negedge clk);
        chk("prereset_count", 64'(u_if.count), 64'd2);
        #2;
        u_if.issue_stall = 1'b0;
        #1;
        chk("prereset_valid", 64'(u_if.issue_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_count", 64'(u_if.count), 64'd0);
        chk("async_valid", 64'(u_if.issue_valid), 64'd0);
        chk("async_full", 64'(u_if.full), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("after_reset_count", 64'(u_if.count), 64'd0);
        chk("after_reset_valid", 64'(u_if.issue_valid), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
